captura_operandos: RTL and testbench

CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

---
 rtl/calc_pkg.sv | 16 +
 rtl/debounce_pulse.sv | 60 ++++++
 rtl/captura_operandos.sv | 82 ++++++++
 tb/tb_captura_operandos.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared widths, FSM states and debounce default for operand capture
package calc_pkg;

  localparam int DATA_W = 4;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    CAP_A  = 2'd0,
    CAP_B  = 2'd1,
    CAP_OP = 2'd2,
    SEND   = 2'd3
  } cap_state_t;

endpackage

// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - button synchronizer, debouncer and press-pulse generator
module debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_pulse_o
);

  // Counter only has to reach DEBOUNCE_CYCLES-1
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_i;
      sync_2 <= sync_1;
    end
  end

  // Adopt the synchronized level once it has disagreed for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered one-cycle pulse on each debounced rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d       <= 1'b0;
      press_pulse_o <= 1'b0;
    end else begin
      level_d       <= level;
      press_pulse_o <= level & ~level_d;
    end
  end

endmodule

// File: rtl/captura_operandos.sv
// rtl/captura_operandos.sv - captures operand A, operand B and ALU code from button presses
module captura_operandos
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              CLK_100MHZ,
  input  logic              rst_n,
  input  logic              btn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              mode_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic [DATA_W-1:0] alu_op_o,
  output logic              valid_o,
  output logic [1:0]        state_o
);

  cap_state_t state;
  logic       press_pulse;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk          (CLK_100MHZ),
    .rst_n        (rst_n),
    .btn_i        (btn_i),
    .press_pulse_o(press_pulse)
  );

  assign state_o = state;

  // Capture sequencer: A, B, ALU code, then hold the triple until accepted
  always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CAP_A;
      op_a_o   <= '0;
      op_b_o   <= '0;
      alu_op_o <= '0;
      valid_o  <= 1'b0;
    end else if (mode_i) begin
      // Leaving calculator mode abandons any partial capture but keeps the registers
      state   <= CAP_A;
      valid_o <= 1'b0;
    end else begin
      case (state)
        CAP_A: begin
          if (press_pulse) begin
            op_a_o <= data_i;
            state  <= CAP_B;
          end
        end
        CAP_B: begin
          if (press_pulse) begin
            op_b_o <= data_i;
            state  <= CAP_OP;
          end
        end
        CAP_OP: begin
          if (press_pulse) begin
            alu_op_o <= data_i;
            state    <= SEND;
            valid_o  <= 1'b1;
          end
        end
        SEND: begin
          // Presses are dropped here, even one coinciding with the handshake
          if (ready_i) begin
            state   <= CAP_A;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= CAP_A;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_captura_operandos.sv
// tb/tb_captura_operandos.sv - self-checking bench for captura_operandos
module tb_captura_operandos;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] data = 4'h0;
  logic       mode = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] op_a_o;
  logic [3:0] op_b_o;
  logic [3:0] alu_op_o;
  logic       valid_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  captura_operandos #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK_100MHZ(clk),
    .rst_n     (rst_n),
    .btn_i     (btn),
    .data_i    (data),
    .mode_i    (mode),
    .ready_i   (ready),
    .op_a_o    (op_a_o),
    .op_b_o    (op_b_o),
    .alu_op_o  (alu_op_o),
    .valid_o   (valid_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Reference model: state/register view plus a sliding-window debounce
  logic [1:0] m_st;
  logic [3:0] m_a, m_b, m_op;
  logic       m_valid;
  logic       m_lvl;
  bit         rose_last, pulse_cur;
  int         hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 2'd0; m_a = 4'h0; m_b = 4'h0; m_op = 4'h0; m_valid = 1'b0;
      m_lvl = 1'b0; rose_last = 1'b0; pulse_cur = 1'b0;
      hist.delete();
    end else begin
      bit flip;
      int n;
      if (mode) m_st = 2'd0;
      else if (m_st == 2'd3) begin
        if (ready) m_st = 2'd0;
      end else if (pulse_cur) begin
        case (m_st)
          2'd0: m_a = data;
          2'd1: m_b = data;
          default: m_op = data;
        endcase
        m_st = m_st + 2'd1;
      end
      m_valid = (m_st == 2'd3);
      // The synchronized button seen at edge k is the raw sample from edge k-2;
      // the level flips when the last N such values all disagree with it.
      hist.push_back(int'(btn));
      n = hist.size();
      flip = 1'b1;
      for (int k = n - N; k < n; k++) begin
        int s;
        s = (k - 2 >= 0) ? hist[k - 2] : 0;
        if (s == int'(m_lvl)) flip = 1'b0;
      end
      pulse_cur = rose_last;
      rose_last = flip && !m_lvl;
      if (flip) m_lvl = ~m_lvl;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_state", 32'(state_o), 32'(m_st));
      check("cyc_valid", 32'(valid_o), 32'(m_valid));
      check("cyc_op_a", 32'(op_a_o), 32'(m_a));
      check("cyc_op_b", 32'(op_b_o), 32'(m_b));
      check("cyc_alu_op", 32'(alu_op_o), 32'(m_op));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    data = d; btn = 1'b1;
    tick(10);
    btn = 1'b0; data = ~d;
    tick(10);
  endtask

  // Press and count edges from the button edge until the state moves
  task automatic press_timed(input logic [3:0] d, input int want, input string name);
    logic [1:0] s0;
    int n;
    s0 = state_o; n = 0;
    data = d; btn = 1'b1;
    while (state_o == s0 && n < 30) begin
      tick(1);
      n++;
    end
    check(name, 32'(n), 32'(want));
    tick(2);
    btn = 1'b0; data = ~d;
    tick(10);
  endtask

  task automatic check_outs(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] op, input logic v, input logic [1:0] s);
    check({name, "_a"}, 32'(op_a_o), 32'(a));
    check({name, "_b"}, 32'(op_b_o), 32'(b));
    check({name, "_alu"}, 32'(alu_op_o), 32'(op));
    check({name, "_valid"}, 32'(valid_o), 32'(v));
    check({name, "_state"}, 32'(state_o), 32'(s));
  endtask

  initial begin
    tick(3);
    check_outs("reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    rst_n = 1'b1;
    checking = 1'b1;
    tick(2);

    // Three clean presses, ready low; first one pins end-to-end latency
    press_timed(4'h6, N + 4, "latency_first");
    press(4'hA);
    press(4'h3);
    check_outs("seq1", 4'h6, 4'hA, 4'h3, 1'b1, 2'd3);
    check("model_seq1_a", 32'(m_a), 32'h6);
    check("model_seq1_st", 32'(m_st), 32'd3);
    tick(5);
    check_outs("seq1_hold", 4'h6, 4'hA, 4'h3, 1'b1, 2'd3);

    // Press while waiting in SEND is ignored
    press(4'hD);
    check_outs("send_press", 4'h6, 4'hA, 4'h3, 1'b1, 2'd3);

    // Pulse lands in the same cycle as the handshake: dropped, FSM returns to A
    data = 4'hE; btn = 1'b1;
    tick(N + 3);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check_outs("collide", 4'h6, 4'hA, 4'h3, 1'b0, 2'd0);
    tick(2);
    btn = 1'b0;
    tick(10);
    check_outs("collide_after", 4'h6, 4'hA, 4'h3, 1'b0, 2'd0);

    // Bouncy press gives a single advance
    data = 4'h5;
    btn = 1'b1; tick(2); btn = 1'b0; tick(2);
    btn = 1'b1; tick(2); btn = 1'b0; tick(2);
    btn = 1'b1; tick(10); btn = 1'b0; tick(10);
    check_outs("bounce", 4'h5, 4'hA, 4'h3, 1'b0, 2'd1);

    // Reset in CAP_OP clears everything immediately
    press(4'h9);
    check("pre_reset_state", 32'(state_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);

    // Button held across reset release: pulse only after a full debounce
    data = 4'h7; btn = 1'b1;
    tick(3);
    rst_n = 1'b1;
    press_timed(4'h7, N + 4, "latency_after_reset");
    press(4'h8);
    press(4'h2);
    check_outs("seq2", 4'h7, 4'h8, 4'h2, 1'b1, 2'd3);

    // One-cycle ready completes the transfer
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check_outs("handshake", 4'h7, 4'h8, 4'h2, 1'b0, 2'd0);
    tick(3);

    // Leaving calculator mode in CAP_B
    press(4'hC);
    check("mode_pre_state", 32'(state_o), 32'd1);
    mode = 1'b1;
    tick(1);
    check("mode_state", 32'(state_o), 32'd0);
    press(4'h1);
    press(4'h4);
    check_outs("mode_presses", 4'hC, 4'h8, 4'h2, 1'b0, 2'd0);
    mode = 1'b0;
    tick(2);
    press(4'hF);
    check_outs("mode_back", 4'hF, 4'h8, 4'h2, 1'b0, 2'd1);
    check("model_mode_back_a", 32'(m_a), 32'hF);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
